// File: rtl/term_quant_pkg.sv
// Shared constants and state encoding for the term-index emitter and the
// downstream one-hot term-mask demux.
package term_quant_pkg;

    // Width of one term word; bit i set means term 2^i is present.
    localparam int DATA_W = 8;
    // Width of an emitted bit index.
    localparam int SEL_W  = 3;
    // Width of the term budget and the emitted-term counter; holds DATA_W.
    localparam int CNT_W  = 4;

    // Control states of the emitter.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage : term_quant_pkg

// File: rtl/msb_prio_enc.sv
// Combinational MSB-first priority encoder: returns the index of the highest
// set bit of vec_i, and flags whether any bit is set at all.
module msb_prio_enc #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 3
) (
    input  logic [IN_W-1:0]  vec_i,
    output logic [OUT_W-1:0] idx_o,
    output logic             any_set_o
);

    // Ascending scan: a later (higher) set bit overrides any lower one.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (vec_i[i]) begin
                idx_o = OUT_W'(i);
            end
        end
    end

    assign any_set_o = |vec_i;

endmodule : msb_prio_enc

// File: rtl/term_index_emitter.sv
// Accepts one term word per transaction and streams out the bit index of
// each set bit, highest first, one per sel handshake, stopping at a per-word
// term budget. A one-cycle done pulse closes each word, with truncated
// reporting whether set bits were left behind.
module term_index_emitter
    import term_quant_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CNT_W-1:0]  max_terms,
    output logic [SEL_W-1:0]  sel,
    output logic              sel_valid,
    input  logic              sel_ready,
    output logic              last,
    output logic              done,
    output logic              truncated
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic [DATA_W-1:0] work_q,      work_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic [CNT_W-1:0]  budget_q,    budget_d;
    logic              in_ready_q,  in_ready_d;
    logic              done_q,      done_d;
    logic              truncated_q, truncated_d;

    // ------------------------------------------------------------------
    // Datapath derived from the registered work word
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]  enc_idx;
    logic              enc_any;
    logic [DATA_W-1:0] work_clr;
    logic [CNT_W-1:0]  count_inc;
    logic              last_c;
    logic              accept;
    logic              sel_fire;
    logic              emitting;

    msb_prio_enc #(
        .IN_W  (DATA_W),
        .OUT_W (SEL_W)
    ) u_msb_prio_enc (
        .vec_i     (work_q),
        .idx_o     (enc_idx),
        .any_set_o (enc_any)
    );

    // Work word with the currently presented bit removed, and the count
    // after this handshake. A budget above DATA_W can never be hit by the
    // counter before the work word empties, so it acts as unlimited.
    assign work_clr  = work_q & ~(DATA_W'(1) << enc_idx);
    assign count_inc = count_q + CNT_W'(1);
    assign last_c    = (work_clr == '0) || (count_inc == budget_q);

    // EMIT is only ever entered with a non-empty word, so enc_any is a
    // consistency guard rather than a functional qualifier.
    assign emitting  = (state_q == EMIT) && enc_any;

    assign accept    = in_valid && in_ready_q;
    assign sel_fire  = emitting && sel_ready;

    // ------------------------------------------------------------------
    // Outputs: sel/last depend only on registers, so they stay stable
    // while the downstream stalls.
    // ------------------------------------------------------------------
    assign in_ready  = in_ready_q;
    assign sel_valid = emitting;
    assign sel       = emitting ? enc_idx : '0;
    assign last      = emitting && last_c;
    assign done      = done_q;
    assign truncated = truncated_q;

    // Next-state logic for the control FSM, counters and word bookkeeping.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        count_d     = count_q;
        budget_d    = budget_q;
        in_ready_d  = in_ready_q;
        done_d      = 1'b0;
        truncated_d = truncated_q;

        unique case (state_q)
            IDLE: begin
                // in_ready is re-armed here so it rises one cycle after reset.
                in_ready_d = 1'b1;
                if (accept) begin
                    work_d   = in_data;
                    budget_d = max_terms;
                    count_d  = '0;
                    if ((in_data == '0) || (max_terms == '0)) begin
                        // Nothing to emit: finish immediately, flag any
                        // bits that a zero budget threw away.
                        done_d      = 1'b1;
                        truncated_d = (in_data != '0);
                    end else begin
                        state_d    = EMIT;
                        in_ready_d = 1'b0;
                    end
                end
            end

            EMIT: begin
                in_ready_d = 1'b0;
                if (sel_fire) begin
                    work_d  = work_clr;
                    count_d = count_inc;
                    if (last_c) begin
                        state_d     = IDLE;
                        in_ready_d  = 1'b1;
                        done_d      = 1'b1;
                        truncated_d = (work_clr != '0);
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            work_q      <= '0;
            count_q     <= '0;
            budget_q    <= '0;
            in_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            truncated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            count_q     <= count_d;
            budget_q    <= budget_d;
            in_ready_q  <= in_ready_d;
            done_q      <= done_d;
            truncated_q <= truncated_d;
        end
    end

endmodule : term_index_emitter

// File: tb/tb_term_index_emitter.sv
// Directed bench for term_index_emitter: a table of whole-word transactions
// plus hand-written sequences for backpressure, reset mid-word and
// back-to-back words.
module tb_term_index_emitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] max_terms;
    logic [2:0] sel;
    logic       sel_valid;
    logic       sel_ready;
    logic       last;
    logic       done;
    logic       truncated;

    int tests_run = 0;
    int tests_failed = 0;

    term_index_emitter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .max_terms (max_terms),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .last      (last),
        .done      (done),
        .truncated (truncated)
    );

    always #5 clk = ~clk;

    // One word: stimulus, expected index sequence (first emitted in the top
    // nibble), expected truncated flag and the mask a demux would collect.
    typedef struct {
        string      name;
        logic [7:0] data;
        logic [3:0] budget;
        int         n;
        logic [31:0] seq;
        logic       trunc;
        logic [7:0] mask;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            $display("[TB] ok   %s: %0d", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int budget;
        budget = 0;
        while (!in_ready && budget < 50) begin
            step();
            budget++;
        end
        if (!in_ready) chk({nm, "_ready_timeout"}, 0, 1);
    endtask

    // Offer a word, follow the sel stream (sel_ready held high) to done.
    task automatic run_word(input string nm, input logic [7:0] d, input logic [3:0] b,
                            input int n, input logic [31:0] seq, input logic tr,
                            input logic [7:0] m);
        int         got;
        int         cyc;
        logic [7:0] mask;
        logic       seen_done;
        logic [3:0] e;
        wait_ready(nm);
        sel_ready = 1'b1;
        in_data   = d;
        max_terms = b;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        got = 0;
        mask = '0;
        seen_done = 1'b0;
        cyc = 0;
        while (!seen_done && cyc < 30) begin
            if (done) begin
                seen_done = 1'b1;
                chk({nm, "_trunc"}, int'(truncated), int'(tr));
                chk({nm, "_ready_at_done"}, int'(in_ready), 1);
            end else begin
                if (sel_valid) begin
                    if (got >= n) begin
                        chk({nm, "_extra_index"}, got, n - 1);
                    end else begin
                        e = seq[31 - 4*got -: 4];
                        chk($sformatf("%s_sel%0d", nm, got), int'(sel), int'(e[2:0]));
                        chk($sformatf("%s_last%0d", nm, got), int'(last), int'(got == n - 1));
                    end
                    mask = mask | (8'd1 << sel);
                    got++;
                end
                step();
                cyc++;
            end
        end
        chk({nm, "_done_seen"}, int'(seen_done), 1);
        chk({nm, "_count"}, got, n);
        chk({nm, "_mask"}, int'(mask), int'(m));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"b4_full",   8'hB4, 4'd8,  4, 32'h7542_0000, 1'b0, 8'hB4};
        vecs[1] = '{"b4_bud2",   8'hB4, 4'd2,  2, 32'h7500_0000, 1'b1, 8'hA0};
        vecs[2] = '{"zero_word", 8'h00, 4'd8,  0, 32'h0000_0000, 1'b0, 8'h00};
        vecs[3] = '{"zero_bud",  8'h81, 4'd0,  0, 32'h0000_0000, 1'b1, 8'h00};
        vecs[4] = '{"ff_unlim",  8'hFF, 4'd15, 8, 32'h7654_3210, 1'b0, 8'hFF};
        vecs[5] = '{"one_bit",   8'h01, 4'd1,  1, 32'h0000_0000, 1'b0, 8'h01};
        vecs[6] = '{"5a_bud3",   8'h5A, 4'd3,  3, 32'h6430_0000, 1'b1, 8'h58};
        vecs[7] = '{"msb_only",  8'h80, 4'd8,  1, 32'h7000_0000, 1'b0, 8'h80};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        max_terms = '0;
        sel_ready = 1'b1;

        // Reset state.
        step();
        step();
        chk("rst_sel_valid", int'(sel_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_trunc", int'(truncated), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_sel", int'(sel), 0);
        reset = 1'b0;
        step();
        chk("rst_ready_after", int'(in_ready), 1);

        // Table-driven words.
        for (int i = 0; i < 8; i++) begin
            run_word(vecs[i].name, vecs[i].data, vecs[i].budget, vecs[i].n,
                     vecs[i].seq, vecs[i].trunc, vecs[i].mask);
        end

        // Truncated flag held until the next done.
        run_word("hold_tr", 8'hB4, 4'd2, 2, 32'h7500_0000, 1'b1, 8'hA0);
        step();
        step();
        chk("trunc_held", int'(truncated), 1);
        chk("done_pulse_only", int'(done), 0);

        // Backpressure on the first index of 0x81.
        wait_ready("bp");
        sel_ready = 1'b0;
        in_data   = 8'h81;
        max_terms = 4'd8;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_valid%0d", k), int'(sel_valid), 1);
            chk($sformatf("bp_sel%0d", k), int'(sel), 7);
            chk($sformatf("bp_last%0d", k), int'(last), 0);
            step();
        end
        sel_ready = 1'b1;
        chk("bp_valid3", int'(sel_valid), 1);
        chk("bp_sel3", int'(sel), 7);
        step();
        chk("bp_second_sel", int'(sel), 0);
        chk("bp_second_last", int'(last), 1);
        chk("bp_second_valid", int'(sel_valid), 1);
        step();
        chk("bp_done", int'(done), 1);
        chk("bp_trunc", int'(truncated), 0);
        chk("bp_no_dup", int'(sel_valid), 0);

        // Reset in EMIT after the first handshake of 0xFF.
        wait_ready("rmid");
        in_data   = 8'hFF;
        max_terms = 4'd8;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        chk("rmid_sel0", int'(sel), 7);
        step();
        chk("rmid_sel1", int'(sel), 6);
        reset = 1'b1;
        step();
        chk("rmid_valid", int'(sel_valid), 0);
        chk("rmid_done", int'(done), 0);
        reset = 1'b0;
        step();
        chk("rmid_ready", int'(in_ready), 1);
        chk("rmid_valid_after", int'(sel_valid), 0);
        run_word("rmid_new", 8'h01, 4'd8, 1, 32'h0000_0000, 1'b0, 8'h01);

        // Back-to-back words with in_valid held.
        wait_ready("b2b");
        in_data   = 8'h03;
        max_terms = 4'd8;
        in_valid  = 1'b1;
        step();
        chk("b2b_sel0", int'(sel), 1);
        chk("b2b_last0", int'(last), 0);
        in_data = 8'h40;
        step();
        chk("b2b_sel1", int'(sel), 0);
        chk("b2b_last1", int'(last), 1);
        step();
        chk("b2b_done1", int'(done), 1);
        chk("b2b_ready1", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("b2b_sel2", int'(sel), 6);
        chk("b2b_last2", int'(last), 1);
        chk("b2b_valid2", int'(sel_valid), 1);
        chk("b2b_nodone", int'(done), 0);
        step();
        chk("b2b_done2", int'(done), 1);
        chk("b2b_trunc2", int'(truncated), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_term_index_emitter

// File: doc/term_index_emitter.md
Name: term_index_emitter

Overview:
- Upstream stage of the one-hot term-mask demux.
- Accepts one 8-bit term word per transaction and emits the bit index of each set bit, MSB first, one index per handshake on a sel[2:0] stream.
- Stops after a per-word term budget; reports whether any set bits were dropped (truncation).
- Its sel/sel_valid output drives the demux select, so the demux accumulates the kept-term mask.

Parameters:
DATA_W, 8, width of term word (power of two)
SEL_W, 3, index width = log2(DATA_W)
CNT_W, 4, budget/counter width; must hold DATA_W

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  term word offered
in_ready  output  1  block can accept a word (high only in IDLE)
in_data  input  DATA_W  term word; bit i set = term 2^i present
max_terms  input  CNT_W  term budget for this word, sampled with in_data
sel  output  SEL_W  index of current emitted term
sel_valid  output  1  sel holds a valid index
sel_ready  input  1  downstream accepts sel
last  output  1  qualifies sel_valid: final index for this word
done  output  1  one-cycle pulse, word finished
truncated  output  1  valid with done: set bits remained when budget ran out

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset (any state, including mid-word): state=IDLE; work reg, count, budget cleared; sel=0, sel_valid=0, last=0, done=0, truncated=0. in_ready rises the cycle after reset deasserts.
- States: IDLE, EMIT.
- IDLE: in_ready=1.
  - Accept on in_valid&&in_ready at edge T: work<=in_data, budget<=max_terms, count<=0.
  - If in_data==0 or max_terms==0: stay IDLE; done=1 at T+1; truncated=(in_data!=0). No sel_valid.
  - Else: go to EMIT; sel_valid=1 from T+1.
- EMIT: in_ready=0.
  - sel = index of highest set bit of work (priority encode of registered work; combinational from registers).
  - last = (work with that bit cleared ==0) || (count+1==budget).
  - sel, last stable while sel_valid&&!sel_ready. No index may be dropped or repeated under backpressure.
- On sel handshake: clear that bit in work; count++.
  - If last: go to IDLE; done=1 next cycle; truncated=(remaining work!=0); in_ready=1 that same cycle.
  - Otherwise the next index is presented the following cycle.
  - Throughput: one index per cycle with sel_ready held high.
- Latency: accept at T, first sel_valid at T+1. Back-to-back words: next accept no earlier than the done cycle.
- Truncated: held until the next done; cleared on reset.
- budget > popcount(in_data): ends on the last set bit, truncated=0.
- max_terms>DATA_W behaves as unlimited.
- sel_ready high while sel_valid low: ignored.

Decomposition:
- Package term_quant_pkg: DATA_W, SEL_W, CNT_W constants; state enum {IDLE, EMIT}. Shared with the demux stage.
- Submodule msb_prio_enc: combinational DATA_W->SEL_W MSB-first priority encoder with any_set output.
- FSM, counters and handshake logic stay in the top module.

Test Plan:
- in_data=0xB4, max_terms=8, sel_ready=1 -> sel=7,5,4,2 on consecutive cycles; last on 2; done next cycle, truncated=0; demux fed from sel ends with mask 0xB4.
- in_data=0xB4, max_terms=2 -> sel=7,5; last on 5; done, truncated=1; downstream mask 0xA0.
- in_data=0x00 (and separately 0x81 with max_terms=0) -> no sel_valid; done at T+1; truncated=0 (resp. 1); in_ready high at T+1.
- in_data=0x81, sel_ready low for 3 cycles on first index -> sel=7 held stable with sel_valid=1 for 4 cycles; then sel=0 with last; no duplicates.
- reset asserted in EMIT after first handshake of 0xFF -> next cycle sel_valid=0, done=0, in_ready=1; new word 0x01 emits sel=0 with last only.
- Two words back-to-back (0x03 then 0x40, in_valid held) -> second word accepted on done cycle; output sequence 1,0(last),6(last).
